// File: rtl/otter_fetch_queue.sv
// ============================================================================
// Module  : otter_fetch_queue
// Brief   : OTTER instruction fetch. Owns the fetch PC, drives Memory port 1
//           and buffers {instruction, PC} pairs for decode (valid/ready).
//           Optional build macro OTTER_FQ_STATS_EN adds stall/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        DE_READY,
    output logic        DE_VALID,
    output logic [31:0] DE_IR,
    output logic [31:0] DE_PC,
    output logic [31:0] DE_PC_INC
`ifdef OTTER_FQ_STATS_EN
    ,
    output logic [15:0] STAT_STALL,
    output logic [15:0] STAT_FLUSHED
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight_vld;
    logic [31:0]   ir_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit;

    assign DE_VALID  = (count != '0) & ~REDIRECT;
    assign pop       = DE_VALID & DE_READY;
    assign push      = inflight_vld & ~REDIRECT;

    // Slots that will be occupied once every outstanding fetch has landed;
    // issuing only below DEPTH guarantees a push can never overflow.
    assign credit    = {1'b0, count} + (CW+1)'(inflight_vld) - (CW+1)'(pop);
    assign issue     = ~RST & ~REDIRECT & (credit < (CW+1)'(DEPTH));

    assign MEM_RDEN1 = issue;
    assign MEM_ADDR1 = fetch_pc[15:2];

    assign DE_IR     = ir_mem[rd_ptr];
    assign DE_PC     = pc_mem[rd_ptr];
    assign DE_PC_INC = DE_PC + 32'd4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc     <= RESET_PC;
            inflight_pc  <= '0;
            inflight_vld <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ir_mem[i] <= '0;
                pc_mem[i] <= '0;
            end
        end else if (REDIRECT) begin
            fetch_pc     <= REDIRECT_PC;
            inflight_vld <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            if (issue) begin
                inflight_pc  <= fetch_pc;
                inflight_vld <= 1'b1;
                fetch_pc     <= fetch_pc + 32'd4;
            end else begin
                inflight_vld <= 1'b0;
            end
            if (push) begin
                ir_mem[wr_ptr] <= MEM_DOUT1;
                pc_mem[wr_ptr] <= inflight_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef OTTER_FQ_STATS_EN
    logic [16:0] flush_sum;

    assign flush_sum = {1'b0, STAT_FLUSHED} + 17'(count) + 17'(inflight_vld);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STAT_STALL   <= '0;
            STAT_FLUSHED <= '0;
        end else begin
            if (DE_VALID && !DE_READY && STAT_STALL != 16'hFFFF) begin
                STAT_STALL <= STAT_STALL + 16'd1;
            end
            if (REDIRECT) begin
                STAT_FLUSHED <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
// ============================================================================
// Module  : tb_otter_fetch_queue
// Brief   : Directed + random stimulus against a queue-based fetch model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_otter_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        MEM_RDEN1;
    logic [13:0] MEM_ADDR1;
    logic [31:0] MEM_DOUT1 = '0;
    logic        DE_READY = 1'b0;
    logic        DE_VALID;
    logic [31:0] DE_IR;
    logic [31:0] DE_PC;
    logic [31:0] DE_PC_INC;
`ifdef OTTER_FQ_STATS_EN
    logic [15:0] STAT_STALL;
    logic [15:0] STAT_FLUSHED;
`endif

    otter_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .MEM_RDEN1   (MEM_RDEN1),
        .MEM_ADDR1   (MEM_ADDR1),
        .MEM_DOUT1   (MEM_DOUT1),
        .DE_READY    (DE_READY),
        .DE_VALID    (DE_VALID),
        .DE_IR       (DE_IR),
        .DE_PC       (DE_PC),
        .DE_PC_INC   (DE_PC_INC)
`ifdef OTTER_FQ_STATS_EN
        ,
        .STAT_STALL  (STAT_STALL),
        .STAT_FLUSHED(STAT_FLUSHED)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: pipeline described as a queue of buffered PCs plus one
    // outstanding fetch; the memory image returns {16'h0, word_addr, 2'b00}.
    logic [31:0] mq[$];
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_pc;
    int          m_stall;
    int          m_flush;
    bit          mem_pend;
    logic [13:0] mem_pend_addr;
    int          issue_cnt;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {16'h0, pc[15:2], 2'b00};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inf    = 1'b0;
        m_inf_pc = '0;
        m_pc     = RESET_PC;
        m_stall  = 0;
        m_flush  = 0;
        mem_pend = 1'b0;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy, input bit rst_pulse);
        bit exp_valid, pop, exp_issue;
        if (rst_pulse) begin
            #1 RST = 1'b1;
            #1;
            check_eq("rst_de_valid", 32'(DE_VALID), 32'd0);
            check_eq("rst_rden", 32'(MEM_RDEN1), 32'd0);
            RST = 1'b0;
            model_reset();
        end
        REDIRECT    = rd;
        REDIRECT_PC = rpc;
        DE_READY    = rdy;
        MEM_DOUT1   = mem_pend ? {16'h0, mem_pend_addr, 2'b00} : $urandom;
        #1;
        exp_valid = (mq.size() != 0) && !rd;
        pop       = exp_valid && rdy;
        exp_issue = !rd && ((mq.size() + int'(m_inf) - int'(pop)) < DEPTH);
        check_eq("de_valid", 32'(DE_VALID), 32'(exp_valid));
        check_eq("rden", 32'(MEM_RDEN1), 32'(exp_issue));
        if (exp_issue) check_eq("addr", 32'(MEM_ADDR1), 32'(m_pc[15:2]));
        if (exp_valid) begin
            check_eq("de_pc", DE_PC, mq[0]);
            check_eq("de_ir", DE_IR, word_of(mq[0]));
            check_eq("de_pc_inc", DE_PC_INC, mq[0] + 32'd4);
        end
`ifdef OTTER_FQ_STATS_EN
        check_eq("stat_stall", 32'(STAT_STALL), 32'(m_stall));
        check_eq("stat_flushed", 32'(STAT_FLUSHED), 32'(m_flush));
`endif
        if (MEM_RDEN1) issue_cnt++;
        mem_pend      = MEM_RDEN1;
        mem_pend_addr = MEM_ADDR1;
        @(posedge CLK);
        if (exp_valid && !rdy) m_stall = (m_stall < 16'hFFFF) ? m_stall + 1 : m_stall;
        if (rd) begin
            m_flush = m_flush + mq.size() + int'(m_inf);
            if (m_flush > 16'hFFFF) m_flush = 16'hFFFF;
            mq.delete();
            m_inf = 1'b0;
            m_pc  = rpc;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inf) mq.push_back(m_inf_pc);
            if (exp_issue) begin
                m_inf_pc = m_pc;
                m_inf    = 1'b1;
                m_pc     = m_pc + 32'd4;
            end else begin
                m_inf = 1'b0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check_eq("reset_de_valid", 32'(DE_VALID), 32'd0);
        check_eq("reset_rden", 32'(MEM_RDEN1), 32'd0);
        check_eq("reset_de_ir", DE_IR, 32'd0);
        check_eq("reset_de_pc", DE_PC, 32'd0);
        check_eq("reset_de_pc_inc", DE_PC_INC, 32'd4);
        @(negedge CLK);
        RST = 1'b0;

        // streaming from reset
        run(10, 1'b1);

        // back-pressure: exactly DEPTH fetches, then release
        cycle(1'b1, 32'h0, 1'b1, 1'b0);
        issue_cnt = 0;
        run(8, 1'b0);
        check_eq("stall_issue_cnt", 32'(issue_cnt), 32'(DEPTH));
        check_eq("stall_head_pc", DE_PC, 32'h0);
        run(12, 1'b1);

        // 3 queued + 1 in flight, then flush
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        run(4, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0);
        run(6, 1'b1);

        // back-to-back redirects
        cycle(1'b1, 32'h200, 1'b1, 1'b0);
        cycle(1'b1, 32'h300, 1'b1, 1'b0);
        run(6, 1'b1);

        // PC wrap-around and misaligned pass-through
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        run(8, 1'b1);
        cycle(1'b1, 32'h0000_0502, 1'b1, 1'b0);
        run(6, 1'b1);

        // asynchronous reset pulse mid-stream
        run(3, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        run(6, 1'b1);

        // five stall cycles with a valid head
        run(5, 1'b0);
        run(4, 1'b1);

        for (int i = 0; i < 500; i++) begin
            bit          rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {16'h0, 14'($urandom), 2'b00};
            cycle(rd, rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
